picorv32_pcpi_issue: RTL

PICORV32_PCPI_ISSUE -- requirements
Module: picorv32_pcpi_issue

---
 rtl/picorv32_pcpi_issue.sv | 127 ++++++++++++
 1 files changed

// File: rtl/picorv32_pcpi_issue.sv
// PCPI issue stage: holds one request on the co-processor interface until a
// co-processor answers, or traps after TIMEOUT unclaimed cycles.
module picorv32_pcpi_issue #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_insn,
    input  logic [31:0] req_rs1,
    input  logic [31:0] req_rs2,
    output logic        pcpi_valid,
    output logic [31:0] pcpi_insn,
    output logic [31:0] pcpi_rs1,
    output logic [31:0] pcpi_rs2,
    input  logic        pcpi_wr,
    input  logic [31:0] pcpi_rd,
    input  logic        pcpi_wait,
    input  logic        pcpi_ready,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_wr,
    output logic [31:0] rsp_rd,
    output logic        rsp_trap,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] insn_q, insn_d;
    logic [31:0] rs1_q, rs1_d;
    logic [31:0] rs2_q, rs2_d;
    logic        rsp_wr_q, rsp_wr_d;
    logic [31:0] rsp_rd_q, rsp_rd_d;
    logic        rsp_trap_q, rsp_trap_d;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            cnt_q      <= 8'd0;
            insn_q     <= 32'd0;
            rs1_q      <= 32'd0;
            rs2_q      <= 32'd0;
            rsp_wr_q   <= 1'b0;
            rsp_rd_q   <= 32'd0;
            rsp_trap_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            insn_q     <= insn_d;
            rs1_q      <= rs1_d;
            rs2_q      <= rs2_d;
            rsp_wr_q   <= rsp_wr_d;
            rsp_rd_q   <= rsp_rd_d;
            rsp_trap_q <= rsp_trap_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        insn_d     = insn_q;
        rs1_d      = rs1_q;
        rs2_d      = rs2_q;
        rsp_wr_d   = rsp_wr_q;
        rsp_rd_d   = rsp_rd_q;
        rsp_trap_d = rsp_trap_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    insn_d  = req_insn;
                    rs1_d   = req_rs1;
                    rs2_d   = req_rs2;
                    cnt_d   = 8'd0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                // A result wins over both a busy claim and an expiring timeout.
                if (pcpi_ready) begin
                    rsp_wr_d   = pcpi_wr;
                    rsp_rd_d   = pcpi_rd;
                    rsp_trap_d = 1'b0;
                    state_d    = RESP;
                end else if (pcpi_wait) begin
                    cnt_d = 8'd0;
                end else if (cnt_q == CNT_LAST) begin
                    rsp_wr_d   = 1'b0;
                    rsp_rd_d   = 32'd0;
                    rsp_trap_d = 1'b1;
                    state_d    = RESP;
                end else if (cnt_q != 8'hFF) begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign req_ready  = (state_q == IDLE);
    assign pcpi_valid = (state_q == ISSUE);
    assign rsp_valid  = (state_q == RESP);
    assign busy       = (state_q != IDLE);
    assign pcpi_insn  = insn_q;
    assign pcpi_rs1   = rs1_q;
    assign pcpi_rs2   = rs2_q;
    assign rsp_wr     = rsp_wr_q;
    assign rsp_rd     = rsp_rd_q;
    assign rsp_trap   = rsp_trap_q;

endmodule
